// File: rtl/data_memory_pkg.sv
// Shared CPU definitions: word width, data-memory depth and the word type.
// Reused by the register file and instruction memory.
package data_memory_pkg;
  localparam int WORD_WIDTH      = 24;
  localparam int CPU_ADDR_WIDTH  = 24;
  localparam int DMEM_DEPTH_LOG2 = 8;

  typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/data_memory_if.sv
// MEM-stage data bus between the datapath (master) and the data memory (slave).
// No valid/ready: an access is issued and completes in the same cycle; writes
// commit on the rising clock edge when MemWrite is 1, reads are combinational.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (output Address, output WriteData, output MemWrite,
                  output MemRead, input ReadData);
  modport slave  (input Address, input WriteData, input MemWrite,
                  input MemRead, output ReadData);
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational gated read,
// asynchronous reset that clears every word.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic        Clock,
  input  logic        Reset,
  data_memory_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] index;
  logic                  writeEn;
  logic                  unusedAddrBits;

  // Upper address bits alias onto the array; they are intentionally dropped.
  assign index          = bus.Address[DEPTH_LOG2-1:0];
  assign unusedAddrBits = ^bus.Address[ADDR_WIDTH-1:DEPTH_LOG2];

  // Only a clean 1 writes, so an unknown enable cannot corrupt the array.
  assign writeEn = (bus.MemWrite === 1'b1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem <= '{default: '0};
    end else if (writeEn) begin
      mem[index] <= bus.WriteData;
    end
  end

  assign bus.ReadData = (!Reset && bus.MemRead) ? mem[index] : '0;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
  import data_memory_pkg::*;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;
  logic [23:0] exp_q[$];

  data_memory_if bus ();

  data_memory dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [23:0] addr, input logic [23:0] data);
    @(negedge Clock);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    @(posedge Clock);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [23:0] addr, input logic [23:0] exp);
    bus.MemRead = 1'b1;
    bus.Address = addr;
    #1;
    check_eq(tag, bus.ReadData, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b1;
    #2;
    check_eq("reset_state", bus.ReadData, 24'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Reset clears asynchronously, mid-cycle
    write_word(24'd5, 24'hABCDEF);
    read_check("pre_reset_5", 24'd5, 24'hABCDEF);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("async_reset_5", bus.ReadData, 24'h0);
    @(negedge Clock);
    Reset = 1'b0;
    read_check("after_reset_5", 24'd5, 24'h0);

    // basic write / read and MemRead gating
    write_word(24'd2, 24'd7);
    bus.MemRead = 1'b0;
    bus.Address = 24'd2;
    #1;
    check_eq("read_gated", bus.ReadData, 24'h0);
    read_check("basic_read_2", 24'd2, 24'd7);

    // write disabled
    @(negedge Clock);
    bus.Address   = 24'd2;
    bus.WriteData = 24'd9;
    bus.MemWrite  = 1'b0;
    @(posedge Clock);
    #1;
    read_check("write_disable_2", 24'd2, 24'd7);

    // aliasing / boundary
    write_word(24'd255, 24'hFFFFFF);
    write_word(24'd256, 24'h000001);
    read_check("alias_0", 24'd0, 24'h000001);
    read_check("boundary_255", 24'd255, 24'hFFFFFF);
    read_check("alias_258", 24'd258, 24'd7);
    read_check("alias_high", 24'hABCD00, 24'h000001);

    // read/write same cycle, no bypass
    write_word(24'd10, 24'd3);
    @(negedge Clock);
    bus.Address   = 24'd10;
    bus.WriteData = 24'd4;
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b1;
    #1;
    check_eq("rw_before_edge", bus.ReadData, 24'd3);
    @(posedge Clock);
    #1;
    check_eq("rw_after_edge", bus.ReadData, 24'd4);
    bus.MemWrite = 1'b0;

    // back-to-back writes on consecutive edges
    for (int i = 0; i < 6; i++) begin
      logic [23:0] d;
      d = 24'h100000 + 24'(i * 24'h1111);
      write_word(24'(30 + i), d);
      exp_q.push_back(d);
    end
    for (int i = 0; i < 6; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      read_check($sformatf("b2b_%0d", 30 + i), 24'(30 + i), e);
    end

    // reset held across a write edge
    @(negedge Clock);
    Reset         = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.Address   = 24'd7;
    bus.WriteData = 24'd5;
    @(posedge Clock);
    #1;
    check_eq("reset_forces_zero", bus.ReadData, 24'h0);
    @(negedge Clock);
    Reset        = 1'b0;
    bus.MemWrite = 1'b0;
    read_check("reset_blocks_write_7", 24'd7, 24'h0);
    read_check("reset_cleared_10", 24'd10, 24'h0);
    read_check("reset_cleared_255", 24'd255, 24'h0);

    // normal writes resume after reset
    write_word(24'd7, 24'h00BEEF);
    read_check("post_reset_write_7", 24'd7, 24'h00BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
